// File: rtl/fht_bitrev_in.sv
// Ping-pong reorder buffer ahead of the FHT butterflies: frames land in bit-reversed address order and drain in natural order.
// First output is registered one clock after a frame's last accept; oREADY drops only while the write bank is still full.
module fht_bitrev_in #(
  parameter int D_BIT  = 17,
  parameter int N_LOG2 = 8
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iCLR,
  input  logic              iVALID,
  input  logic [D_BIT-1:0]  iDATA,
  output logic              oREADY,
  output logic              oVALID,
  output logic [D_BIT-1:0]  oDATA,
  output logic [N_LOG2-1:0] oINDEX,
  output logic              oLAST,
  input  logic              iREADY
);
  localparam int N = 1 << N_LOG2;

  logic [D_BIT-1:0]  mem [2*N];
  logic [1:0]        full;
  logic              wr_bank, rd_bank;
  logic [N_LOG2-1:0] wr_cnt, rd_cnt, wr_addr;
  logic              wr_en, out_free, rd_go;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  assign oREADY   = !full[wr_bank] && !iCLR;
  assign wr_en    = iVALID && oREADY;
  assign out_free = !oVALID || iREADY;
  assign rd_go    = out_free && full[rd_bank] && !iCLR;
  assign wr_addr  = bitrev(wr_cnt);

  // Sample storage is never cleared; the full flags alone decide what is readable.
  always_ff @(posedge iCLK) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= iDATA;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      oVALID  <= 1'b0;
      oDATA   <= '0;
      oINDEX  <= '0;
      oLAST   <= 1'b0;
    end else if (iCLR) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      oVALID  <= 1'b0;
      oLAST   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '1) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      // Write and read sides always point at different banks when both touch a flag.
      if (rd_go) begin
        oDATA  <= mem[{rd_bank, rd_cnt}];
        oINDEX <= rd_cnt;
        oLAST  <= (rd_cnt == '1);
        oVALID <= 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == '1) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end else if (out_free) begin
        oVALID <= 1'b0;
      end
    end
  end
endmodule
